// File: rtl/instr_fetch_decode_if.sv
// Instruction-memory fetch bus between the fetch/decode front end and
// instruction memory.
//
// Handshake: the master raises mem_req with mem_adr and holds both stable
// until the slave returns a one-cycle mem_ack strobe carrying mem_rdata. The
// master lowers mem_req on the edge that samples mem_ack. It never withdraws
// a request early, and it never has more than one request outstanding.
interface instr_fetch_decode_if;
  logic        mem_req;
  logic [31:0] mem_adr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_adr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_adr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/instr_fetch_decode.sv
// RV32I fetch/decode front end. Instructions are fetched over a req/ack bus
// into a small FIFO, then decoded and presented one per cycle. The consumer
// can stall the stage with is_busy and redirect it with get_npc/npc.
module instr_fetch_decode #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_fetch_decode_if.master mem,
  input  logic                 is_busy,
  input  logic                 get_npc,
  input  logic [31:0]          npc,
  output logic                 dec_valid,
  output logic [6:0]           opcode,
  output logic [4:0]           rd,
  output logic [2:0]           fun3,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [6:0]           fun7,
  output logic [31:0]          imm,
  output logic [31:0]          opc,
  output logic                 dbg_state
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t           state, state_d;
  logic [31:0]      pc, pc_d;
  logic             req_q, req_d;
  logic [31:0]      adr_q, adr_d;
  logic             discard, discard_d;
  logic             push, pop;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [31:0]      fifo_instr [FIFO_DEPTH];
  logic [31:0]      fifo_pc    [FIFO_DEPTH];
  logic [31:0]      head_instr;
  logic [31:0]      instr_q;

  assign mem.mem_req = req_q;
  assign mem.mem_adr = adr_q;
  assign dbg_state   = (state == S_REQ);

  // Sign-extended immediate for each RV32I format; R-type and unknown give 0.
  function automatic logic [31:0] imm_decode(input logic [31:0] i);
    case (i[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: imm_decode = {{20{i[31]}}, i[31:20]};
      7'b0100011: imm_decode = {{20{i[31]}}, i[31:25], i[11:7]};
      7'b1100011: imm_decode = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'b0110111, 7'b0010111: imm_decode = {i[31:12], 12'b0};
      7'b1101111: imm_decode = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm_decode = 32'b0;
    endcase
  endfunction

  // Fetch FSM next state: issue only with a free FIFO credit, push on ack
  // unless the response belongs to a request made before a redirect.
  always_comb begin
    state_d   = state;
    pc_d      = pc;
    req_d     = req_q;
    adr_d     = adr_q;
    discard_d = discard;
    push      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!get_npc && (count < DEPTH_C)) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          adr_d   = pc;
        end
      end
      S_REQ: begin
        if (mem.mem_ack) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          if (discard || get_npc) begin
            discard_d = 1'b0;
          end else begin
            push = 1'b1;
            pc_d = pc + 32'd4;
          end
        end else if (get_npc) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (get_npc) pc_d = npc;
  end

  // Fetch FSM state and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      req_q   <= 1'b0;
      adr_q   <= RESET_PC;
      discard <= 1'b0;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      req_q   <= req_d;
      adr_q   <= adr_d;
      discard <= discard_d;
    end
  end

  assign pop        = !get_npc && !is_busy && (count != '0);
  assign head_instr = fifo_instr[rd_ptr];

  // FIFO pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (get_npc) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: the instruction word together with the PC it came from.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= mem.mem_rdata;
      fifo_pc[wr_ptr]    <= pc;
    end
  end

  // Decode register: redirect forces NOP, stall holds, otherwise pop or NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_valid <= 1'b0;
      instr_q   <= '0;
      imm       <= '0;
      opc       <= '0;
    end else if (get_npc) begin
      dec_valid <= 1'b0;
      instr_q   <= '0;
      imm       <= '0;
      opc       <= '0;
    end else if (!is_busy) begin
      if (count != '0) begin
        dec_valid <= 1'b1;
        instr_q   <= head_instr;
        imm       <= imm_decode(head_instr);
        opc       <= fifo_pc[rd_ptr];
      end else begin
        dec_valid <= 1'b0;
        instr_q   <= '0;
        imm       <= '0;
        opc       <= '0;
      end
    end
  end

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign fun3   = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign fun7   = instr_q[31:25];

endmodule
